// File: rtl/pipeline_controller_if.sv
// Handshake bundle between the pipeline sequencing controller and the
// pipeline it drives.
//   Requests into the controller : load_use_stall, branch_taken, ecall_ex,
//                                  io_done, mem_busy
//   Controls out of controller   : pc_en, if_id_en, id_ex_en, ex_mem_en,
//                                  mem_wb_en, if_id_flush, id_ex_flush,
//                                  ex_mem_flush, io_req, io_timeout, busy
// The master modport is the pipeline side, which raises requests and
// consumes controls. The slave modport is the controller.
interface pipeline_controller_if;
    logic load_use_stall;
    logic branch_taken;
    logic ecall_ex;
    logic io_done;
    logic mem_busy;
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic io_req;
    logic io_timeout;
    logic busy;

    modport master (
        output load_use_stall, branch_taken, ecall_ex, io_done, mem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush,
        input  io_req, io_timeout, busy
    );

    modport slave (
        input  load_use_stall, branch_taken, ecall_ex, io_done, mem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush,
        output io_req, io_timeout, busy
    );
endinterface

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. Combines
// the load-use stall, EX-stage branch redirect, ecall I/O wait and data
// memory busy into per-stage register enables and flushes.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-high
//   ctl  - pipeline_controller_if.slave (requests in, enables/flushes out)
//   stall_cycles, flush_count - performance counters, present only when
//                               PIPE_PERF_CNT_EN is defined
// Optional feature macro: PIPE_PERF_CNT_EN
module pipeline_controller #(
    parameter int IO_TIMEOUT = 1023,
    parameter int TO_W       = 10
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_controller_if.slave  ctl
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
`endif
);
    typedef enum logic [1:0] {RUN, FLUSH, ECALL_WAIT} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IO_TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            timed_out;

    // Enable vector order: {pc, if_id, id_ex, ex_mem, mem_wb}
    // Flush vector order:  {if_id, id_ex, ex_mem}
    logic [4:0] en;
    logic [2:0] fl;
    logic       io_req;
    logic       wait_exit;
    logic       branch_flush;

    assign wait_exit = ctl.io_done || (to_cnt == TO_LAST);

    always_comb begin
        en           = 5'b11111;
        fl           = 3'b000;
        io_req       = 1'b0;
        branch_flush = 1'b0;
        if (rst) begin
            en = 5'b00000;
            fl = 3'b111;
        end else if (ctl.mem_busy) begin
            // Whole pipeline freezes; no bubbles so nothing is lost.
            en     = 5'b00000;
            io_req = (state == ECALL_WAIT);
        end else if (state == ECALL_WAIT) begin
            io_req = 1'b1;
            // On exit the enables open for one cycle so the ecall advances once.
            if (!wait_exit) begin
                en = 5'b00001;
                fl = 3'b001;
            end
        end else if (ctl.ecall_ex) begin
            en = 5'b00001;
            fl = 3'b001;
        end else if (ctl.branch_taken) begin
            fl           = 3'b110;
            branch_flush = 1'b1;
        end else if (ctl.load_use_stall && state == RUN) begin
            // In FLUSH the stall request comes from a squashed instruction.
            en = 5'b00111;
            fl = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (!ctl.mem_busy) begin
            case (state)
                ECALL_WAIT: begin
                    if (ctl.io_done) begin
                        state <= RUN;
                    end else if (to_cnt == TO_LAST) begin
                        state     <= RUN;
                        timed_out <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    if (ctl.ecall_ex) begin
                        state  <= ECALL_WAIT;
                        to_cnt <= '0;
                    end else if (ctl.branch_taken) begin
                        state <= FLUSH;
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!en[4] && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (branch_flush && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end
`endif

    assign ctl.pc_en        = en[4];
    assign ctl.if_id_en     = en[3];
    assign ctl.id_ex_en     = en[2];
    assign ctl.ex_mem_en    = en[1];
    assign ctl.mem_wb_en    = en[0];
    assign ctl.if_id_flush  = fl[2];
    assign ctl.id_ex_flush  = fl[1];
    assign ctl.ex_mem_flush = fl[0];
    assign ctl.io_req       = io_req;
    assign ctl.io_timeout   = timed_out;
    assign ctl.busy         = !rst && (state != RUN);
endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios followed
// by randomized requests, compared each cycle against a behavioural model.
module tb_pipeline_controller;
    localparam int IO_TIMEOUT = 8;
    localparam int TO_W       = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_controller_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    pipeline_controller #(
        .IO_TIMEOUT(IO_TIMEOUT),
        .TO_W      (TO_W)
`ifdef PIPE_PERF_CNT_EN
        ,
        .CNT_W     (16)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: spec-level situation, not controller encoding.
    bit m_waiting;     // ecall is parked waiting for I/O
    bit m_shadow;      // the cycle right after a taken branch
    int m_wait_cycles; // non-frozen cycles already spent waiting
    bit m_timed_out;
    int m_stalls;
    int m_flushes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {pc,if_id,id_ex,ex_mem,mem_wb, if_id_fl,id_ex_fl,ex_mem_fl, io_req, io_timeout, busy}
    function automatic logic [10:0] expect_out(bit r, bit ls, bit br, bit ec, bit dn, bit mb);
        logic [4:0] en;
        logic [2:0] fl;
        bit         req;
        bit         bsy;
        en  = 5'b11111;
        fl  = 3'b000;
        req = 1'b0;
        bsy = !r && (m_waiting || m_shadow);
        if (r) begin
            en = 5'b00000;
            fl = 3'b111;
        end else if (mb) begin
            en  = 5'b00000;
            req = m_waiting;
        end else if (m_waiting) begin
            req = 1'b1;
            if (!dn && m_wait_cycles + 1 < IO_TIMEOUT) begin
                en = 5'b00001;
                fl = 3'b001;
            end
        end else if (ec) begin
            en = 5'b00001;
            fl = 3'b001;
        end else if (br) begin
            fl = 3'b110;
        end else if (ls && !m_shadow) begin
            en = 5'b00111;
            fl = 3'b010;
        end
        return {en, fl, req, m_timed_out, bsy};
    endfunction

    task automatic step(input string tag, input bit r, input bit ls, input bit br,
                        input bit ec, input bit dn, input bit mb);
        logic [10:0] exp_v;
        logic [10:0] got_v;
        @(negedge clk);
        rst                = r;
        bus.load_use_stall = ls;
        bus.branch_taken   = br;
        bus.ecall_ex       = ec;
        bus.io_done        = dn;
        bus.mem_busy       = mb;
        #1;
        exp_v = expect_out(r, ls, br, ec, dn, mb);
        got_v = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                 bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
                 bus.io_req, bus.io_timeout, bus.busy};
        check(tag, 32'(got_v), 32'(exp_v));
`ifdef PIPE_PERF_CNT_EN
        check({tag, "_stall_cnt"}, 32'(stall_cycles), 32'(m_stalls));
        check({tag, "_flush_cnt"}, 32'(flush_count), 32'(m_flushes));
`endif
        @(posedge clk);
        // Advance the model with what happened on this edge.
        if (r) begin
            m_waiting = 0; m_shadow = 0; m_wait_cycles = 0; m_timed_out = 0;
            m_stalls = 0; m_flushes = 0;
        end else begin
            if (!exp_v[10] && m_stalls < 65535) m_stalls++;
            if (!mb) begin
                if (m_waiting) begin
                    if (dn) m_waiting = 0;
                    else if (m_wait_cycles + 1 >= IO_TIMEOUT) begin
                        m_waiting = 0; m_timed_out = 1;
                    end else m_wait_cycles++;
                end else if (ec) begin
                    m_waiting = 1; m_wait_cycles = 0; m_shadow = 0;
                end else if (br) begin
                    m_shadow = 1;
                    if (m_flushes < 65535) m_flushes++;
                end else m_shadow = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.load_use_stall = 0; bus.branch_taken = 0; bus.ecall_ex = 0;
        bus.io_done = 0; bus.mem_busy = 0;
        m_waiting = 0; m_shadow = 0; m_wait_cycles = 0; m_timed_out = 0;
        m_stalls = 0; m_flushes = 0;
        @(posedge clk);

        // Reset with arbitrary inputs, then release.
        for (int i = 0; i < 3; i++)
            step("reset", 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step("rst_release", 0, 0, 0, 0, 0, 0);

        // Single load-use stall.
        step("load_use", 0, 1, 0, 0, 0, 0);
        step("load_use_after", 0, 0, 0, 0, 0, 0);

        // Stall in branch shadow is ignored.
        step("branch", 0, 0, 1, 0, 0, 0);
        step("branch_shadow", 0, 1, 0, 0, 0, 0);
        step("branch_back", 0, 0, 0, 0, 0, 0);

        // Ecall serviced after 5 wait cycles.
        step("ecall_enter", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step("ecall_wait", 0, 0, 0, 1, 0, 0);
        step("ecall_done", 0, 0, 0, 1, 1, 0);
        step("ecall_after", 0, 0, 0, 0, 0, 0);

        // Ecall timing out, sticky flag.
        step("to_enter", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < IO_TIMEOUT; i++) step("to_wait", 0, 0, 0, 1, 0, 0);
        step("to_after", 0, 0, 0, 0, 0, 0);
        #1 check("to_sticky", 32'(bus.io_timeout), 32'd1);

        // mem_busy freezes the wait counter for 4 cycles.
        step("mb_enter", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) step("mb_wait", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step("mb_frozen", 0, 1, 1, 1, 0, 1);
        for (int i = 0; i < IO_TIMEOUT - 2; i++) step("mb_wait2", 0, 0, 0, 1, 0, 0);
        step("mb_after", 0, 0, 0, 0, 0, 0);
        step("clr", 1, 0, 0, 0, 0, 0);
        #1 check("to_cleared", 32'(bus.io_timeout), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step("rand",
                 ($urandom_range(99) < 2),
                 ($urandom_range(99) < 25),
                 ($urandom_range(99) < 15),
                 ($urandom_range(99) < 6),
                 ($urandom_range(99) < 8),
                 ($urandom_range(99) < 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
